bcd_alarm_clock: RTL and testbench



---
 rtl/bcd_alarm_clock.sv | 170 +++++++++++++++++
 tb/tb_bcd_alarm_clock.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_alarm_clock.sv
// BCD timekeeping core: prescaled seconds tick, 24h counter with 12h display,
// validated time load, alarm with snooze, and a one-second hourly chime flag.
module bcd_alarm_clock #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned ALARM_SECS = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       EN,
  input  logic       Mode12,
  input  logic       Load,
  input  logic [7:0] SetH,
  input  logic [7:0] SetM,
  input  logic       AlarmEn,
  input  logic [7:0] AlarmH,
  input  logic [7:0] AlarmM,
  input  logic       Snooze,
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic       PM,
  output logic       SecTick,
  output logic       Alarm,
  output logic       Chime,
  output logic       LoadErr
);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  state_e      state, state_n;
  logic [15:0] presc;
  logic [7:0]  h24;
  logic [7:0]  sec_n, min_n, h_n;
  logic [7:0]  ring_cnt, ring_cnt_n;
  logic [6:0]  snz_h, snz_h_n, snz_m, snz_m_n;
  logic [6:0]  m_sum, h_bin, h12;
  logic        tick_adv, load_ok, alarm_hit, snz_hit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  assign SecTick  = EN && (presc == 16'(TICK_DIV - 1));
  // Load outranks the tick, so a coincident tick never advances time or the alarm.
  assign tick_adv = SecTick && !Load;
  assign load_ok  = (SetH[7:4] <= 4'd9) && (SetH[3:0] <= 4'd9) &&
                    (SetM[7:4] <= 4'd9) && (SetM[3:0] <= 4'd9) &&
                    (SetH <= 8'h23) && (SetM <= 8'h59);
  assign Alarm    = (state == StRing);

  always_comb begin
    sec_n = (Second == 8'h59) ? 8'h00 : bcd_inc(Second);
    min_n = Minute;
    h_n   = h24;
    if (Second == 8'h59) begin
      min_n = (Minute == 8'h59) ? 8'h00 : bcd_inc(Minute);
      if (Minute == 8'h59) h_n = (h24 == 8'h23) ? 8'h00 : bcd_inc(h24);
    end
  end

  assign alarm_hit = (h_n == AlarmH) && (min_n == AlarmM) && (sec_n == 8'h00);
  assign snz_hit   = (bcd2bin(h_n) == snz_h) && (bcd2bin(min_n) == snz_m) && (sec_n == 8'h00);
  assign h_bin     = bcd2bin(h24);
  assign m_sum     = bcd2bin(Minute) + 7'(SNOOZE_MIN);
  assign h12       = h_bin - 7'd12;

  always_comb begin
    Hour = h24;
    PM   = 1'b0;
    if (Mode12) begin
      if (h24 == 8'h00) begin
        Hour = 8'h12;
      end else if (h_bin >= 7'd12) begin
        PM = 1'b1;
        if (h24 != 8'h12) Hour = (h12 >= 7'd10) ? {4'd1, 4'(h12 - 7'd10)} : {4'd0, 4'(h12)};
      end
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      presc   <= '0;
      h24     <= 8'h00;
      Minute  <= 8'h00;
      Second  <= 8'h00;
      Chime   <= 1'b0;
      LoadErr <= 1'b0;
    end else begin
      LoadErr <= Load && !load_ok;
      if (Load && load_ok) begin
        presc  <= '0;
        h24    <= SetH;
        Minute <= SetM;
        Second <= 8'h00;
        Chime  <= 1'b0;
      end else begin
        if (EN) presc <= SecTick ? '0 : presc + 16'd1;
        if (tick_adv) begin
          Second <= sec_n;
          Minute <= min_n;
          h24    <= h_n;
          Chime  <= (min_n == 8'h00) && (sec_n == 8'h00);
        end
      end
    end
  end

  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    snz_h_n    = snz_h;
    snz_m_n    = snz_m;
    if (!AlarmEn) begin
      state_n = StIdle;
    end else if (EN) begin
      case (state)
        StIdle: begin
          if (tick_adv && alarm_hit) begin
            state_n    = StRing;
            ring_cnt_n = 8'(ALARM_SECS);
          end
        end
        StRing: begin
          if (Snooze) begin
            state_n = StSnooze;
            if (m_sum >= 7'd60) begin
              snz_m_n = m_sum - 7'd60;
              snz_h_n = (h_bin == 7'd23) ? 7'd0 : h_bin + 7'd1;
            end else begin
              snz_m_n = m_sum;
              snz_h_n = h_bin;
            end
          end else if (tick_adv) begin
            if (alarm_hit) ring_cnt_n = 8'(ALARM_SECS);
            else if (ring_cnt <= 8'd1) state_n = StIdle;
            else ring_cnt_n = ring_cnt - 8'd1;
          end
        end
        StSnooze: begin
          if (tick_adv && snz_hit) begin
            state_n    = StRing;
            ring_cnt_n = 8'(ALARM_SECS);
          end
        end
        default: state_n = StIdle;
      endcase
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state    <= StIdle;
      ring_cnt <= 8'd0;
      snz_h    <= 7'd0;
      snz_m    <= 7'd0;
    end else begin
      state    <= state_n;
      ring_cnt <= ring_cnt_n;
      snz_h    <= snz_h_n;
      snz_m    <= snz_m_n;
    end
  end

endmodule

// File: tb/tb_bcd_alarm_clock.sv
// Scoreboard bench for bcd_alarm_clock: a seconds-of-day model queues the expected
// state for every tick; a monitor pops and compares whenever the DUT ticks.
module tb_bcd_alarm_clock;
  localparam int TD = 4;
  localparam int AS = 3;
  localparam int SM = 5;

  logic       CP = 1'b0;
  logic       CR, EN, Mode12, Load, AlarmEn, Snooze;
  logic [7:0] SetH, SetM, AlarmH, AlarmM;
  logic [7:0] Hour, Minute, Second;
  logic       PM, SecTick, Alarm, Chime, LoadErr;

  bcd_alarm_clock #(.TICK_DIV(TD), .ALARM_SECS(AS), .SNOOZE_MIN(SM)) dut (
    .CP(CP), .CR(CR), .EN(EN), .Mode12(Mode12), .Load(Load), .SetH(SetH), .SetM(SetM),
    .AlarmEn(AlarmEn), .AlarmH(AlarmH), .AlarmM(AlarmM), .Snooze(Snooze),
    .Hour(Hour), .Minute(Minute), .Second(Second), .PM(PM), .SecTick(SecTick),
    .Alarm(Alarm), .Chime(Chime), .LoadErr(LoadErr)
  );

  always #5 CP = ~CP;

  typedef struct {int t; bit alarm; bit chime;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0;
  int   m_pre, m_t, m_st, m_cnt, m_tgt, m_ticks;
  bit   m_chime, m_err, prev_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // {PM, Hour} as the display should show it for seconds-of-day t
  function automatic logic [8:0] exp_disp(input int t);
    int h;
    h = t / 3600;
    if (!Mode12) return {1'b0, bcd(h)};
    return {h >= 12, bcd((h % 12 == 0) ? 12 : h % 12)};
  endfunction

  task automatic model_step();
    bit tick, adv, ok;
    int old_t, al_t;
    tick  = EN && (m_pre == TD - 1);
    adv   = tick && !Load;
    old_t = m_t;
    ok    = SetH[7:4] <= 9 && SetH[3:0] <= 9 && SetM[7:4] <= 9 && SetM[3:0] <= 9 &&
            dec(SetH) < 24 && dec(SetM) < 60;
    m_err = Load && !ok;
    if (Load && ok) begin
      m_t = dec(SetH) * 3600 + dec(SetM) * 60;
      m_pre = 0;
      m_chime = 0;
    end else begin
      if (EN) m_pre = tick ? 0 : m_pre + 1;
      if (adv) begin
        m_t = (m_t + 1) % 86400;
        m_chime = (m_t % 3600 == 0);
      end
    end
    al_t = dec(AlarmH) * 3600 + dec(AlarmM) * 60;
    if (!AlarmEn) m_st = 0;
    else if (EN) begin
      case (m_st)
        0: if (adv && m_t == al_t) begin m_st = 1; m_cnt = AS; end
        1: begin
          if (Snooze) begin
            m_st = 2;
            m_tgt = ((old_t / 60 + SM) % 1440) * 60;
          end else if (adv) begin
            if (m_t == al_t) m_cnt = AS;
            else begin
              m_cnt--;
              if (m_cnt == 0) m_st = 0;
            end
          end
        end
        default: if (adv && m_t == m_tgt) begin m_st = 1; m_cnt = AS; end
      endcase
    end
    if (tick) begin
      sb.push_back('{m_t, m_st == 1, m_chime});
      m_ticks++;
    end
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic cycle();
    model_step();
    @(posedge CP);
    #1;
    if (Load) check_val("loaderr", {31'd0, LoadErr}, {31'd0, m_err});
    else if (prev_err) check_val("loaderr_pulse", {31'd0, LoadErr}, 32'd0);
    prev_err = Load && m_err;
    Load = 1'b0;
    Snooze = 1'b0;
    @(negedge CP);
  endtask

  task automatic run_ticks(input int n);
    int target, guard;
    target = m_ticks + n;
    guard = 0;
    while (m_ticks < target && guard < n * TD + 8) begin
      cycle();
      guard++;
    end
    check_val("tick_budget", {31'd0, m_ticks >= target}, 32'd1);
  endtask

  task automatic load_time(input logic [7:0] h, input logic [7:0] m);
    SetH = h;
    SetM = m;
    Load = 1'b1;
    cycle();
  endtask

  task automatic check_time(input string tag);
    check_val({tag, "_sec"}, {24'd0, Second}, {24'd0, bcd(m_t % 60)});
    check_val({tag, "_min"}, {24'd0, Minute}, {24'd0, bcd((m_t / 60) % 60)});
    check_val({tag, "_hour"}, {23'd0, PM, Hour}, {23'd0, exp_disp(m_t)});
  endtask

  task automatic model_reset();
    m_pre = 0; m_t = 0; m_st = 0; m_cnt = 0; m_tgt = 0; m_chime = 0;
    prev_err = 0;
    sb.delete();
  endtask

  always @(posedge CP) begin
    if (SecTick && !CR) begin
      #1;
      if (sb.size() == 0) begin
        check_val("sb_unexpected_tick", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("sb_sec", {24'd0, Second}, {24'd0, bcd(mon_e.t % 60)});
        check_val("sb_min", {24'd0, Minute}, {24'd0, bcd((mon_e.t / 60) % 60)});
        check_val("sb_hour", {23'd0, PM, Hour}, {23'd0, exp_disp(mon_e.t)});
        check_val("sb_alarm", {31'd0, Alarm}, {31'd0, mon_e.alarm});
        check_val("sb_chime", {31'd0, Chime}, {31'd0, mon_e.chime});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    CR = 1'b1; EN = 1'b0; Mode12 = 1'b0; Load = 1'b0; AlarmEn = 1'b0; Snooze = 1'b0;
    SetH = 8'h00; SetM = 8'h00; AlarmH = 8'h00; AlarmM = 8'h00;
    m_ticks = 0;
    model_reset();
    repeat (2) @(negedge CP);
    check_val("rst_hour24", {24'd0, Hour}, 32'h00);
    check_val("rst_min", {24'd0, Minute}, 32'h00);
    check_val("rst_sec", {24'd0, Second}, 32'h00);
    check_val("rst_flags", {27'd0, PM, SecTick, Alarm, Chime, LoadErr}, 32'd0);
    Mode12 = 1'b1;
    #1;
    check_val("rst_hour12", {23'd0, PM, Hour}, {23'd0, 9'h012});
    Mode12 = 1'b0;
    @(negedge CP);
    CR = 1'b0;
    EN = 1'b1;

    // Free run one minute; every tick checked by the scoreboard.
    run_ticks(60);
    check_val("one_minute", {16'd0, Minute, Second}, 32'h0100);

    // Freeze.
    EN = 1'b0;
    repeat (10) cycle();
    check_time("frozen");
    EN = 1'b1;

    // Midnight rollover in 12h mode with chime.
    Mode12 = 1'b1;
    load_time(8'h23, 8'h59);
    run_ticks(60);
    check_val("midnight", {23'd0, PM, Hour}, {23'd0, 9'h012});
    run_ticks(2);

    // Rejected loads leave time unchanged.
    Mode12 = 1'b0;
    load_time(8'h24, 8'h10);
    check_time("rej_h24");
    cycle();
    load_time(8'h12, 8'h5A);
    check_time("rej_m5a");
    load_time(8'h1A, 8'h00);
    check_time("rej_h1a");

    // Load coincident with a tick.
    while (m_pre != TD - 1) cycle();
    load_time(8'h10, 8'h20);
    check_time("load_on_tick");
    check_val("load_on_tick_sec", {24'd0, Second}, 32'h00);
    run_ticks(3);

    // 12h display conversions.
    Mode12 = 1'b1;
    load_time(8'h13, 8'h00);
    check_val("disp_13", {23'd0, PM, Hour}, {23'd0, 9'h101});
    load_time(8'h12, 8'h00);
    check_val("disp_12", {23'd0, PM, Hour}, {23'd0, 9'h112});
    load_time(8'h11, 8'h00);
    check_val("disp_11", {23'd0, PM, Hour}, {23'd0, 9'h011});
    load_time(8'h21, 8'h30);
    check_val("disp_21", {23'd0, PM, Hour}, {23'd0, 9'h109});
    Mode12 = 1'b0;
    #1;
    check_val("disp_24h", {23'd0, PM, Hour}, {23'd0, 9'h021});

    // Alarm at 07:30 rings for three seconds.
    AlarmH = 8'h07; AlarmM = 8'h30; AlarmEn = 1'b1;
    load_time(8'h07, 8'h29);
    run_ticks(60);
    check_val("alarm_rise", {31'd0, Alarm}, 32'd1);
    run_ticks(3);
    check_val("alarm_fall", {31'd0, Alarm}, 32'd0);

    // Snooze at 07:30:01, re-ring at 07:35:00, then async clear mid-ring.
    load_time(8'h07, 8'h29);
    run_ticks(61);
    check_val("ring_0730_01", {31'd0, Alarm}, 32'd1);
    Snooze = 1'b1;
    cycle();
    check_val("snoozed", {31'd0, Alarm}, 32'd0);
    run_ticks(298);
    check_val("snooze_quiet", {31'd0, Alarm}, 32'd0);
    run_ticks(1);
    check_val("rering", {15'd0, Alarm, Minute, Second}, 32'h13500);
    run_ticks(1);
    #2;
    CR = 1'b1;
    #1;
    check_val("cr_alarm", {31'd0, Alarm}, 32'd0);
    check_val("cr_time", {8'd0, Hour, Minute, Second}, 32'd0);
    model_reset();
    @(negedge CP);
    CR = 1'b0;
    run_ticks(2);

    check_val("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
